// File: rtl/sprite_blitter.sv
// CHIP-8/SCHIP DXYN draw sequencer: fetches sprite bytes from RAM and XORs them into VRAM.
// Optional build macro SPRITE_WRAP_EN: off-screen pixels wrap to the opposite edge instead of clipping.
module sprite_blitter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hires,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] sprite_addr,
    input  logic [1:0]        plane_mask,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [6:0]        vram_hpos,
    output logic [5:0]        vram_vpos,
    input  logic [1:0]        vram_pixelo,
    output logic [1:0]        vram_pixeli,
    output logic              vram_we
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_RD    = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Screen dimensions are powers of two, so wrapping is a bit mask.
    function automatic logic [6:0] wrap_col(input logic [7:0] c, input logic hr);
        return hr ? c[6:0] : {1'b0, c[5:0]};
    endfunction

    function automatic logic [5:0] wrap_row(input logic [7:0] r, input logic hr);
        return hr ? r[5:0] : {1'b0, r[4:0]};
    endfunction

    logic [2:0]        state_q, state_d;
    logic              coll_q, coll_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [6:0]        hpos_q, hpos_d;
    logic [5:0]        vpos_q, vpos_d;

    logic              hires_q, hires_d;
    logic              wide_q, wide_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [4:0]        rows_q, rows_d;
    logic [1:0]        mask_q, mask_d;
    logic [15:0]       sprite_q, sprite_d;
    logic              byte_q, byte_d;
    logic [3:0]        px_q, px_d;
    logic [3:0]        row_q, row_d;

    logic [7:0]        cur_col;
    logic [7:0]        nxt_col;
    logic [7:0]        cur_row;
    logic              pix_bit;
    logic              visible;
    logic              write_en;
    logic              last_px;
    logic              last_row;

    always_comb begin
        cur_col  = x_q + {4'b0000, px_q};
        nxt_col  = cur_col + 8'd1;
        cur_row  = y_q + {4'b0000, row_q};
        pix_bit  = sprite_q[4'd15 - px_q];
`ifdef SPRITE_WRAP_EN
        visible  = 1'b1;
`else
        visible  = hires_q ? (cur_col < 8'd128 && cur_row < 8'd64)
                           : (cur_col < 8'd64  && cur_row < 8'd32);
`endif
        write_en = (state_q == ST_WR) && pix_bit && (mask_q != 2'b00) && visible;
        last_px  = wide_q ? (px_q == 4'd15) : (px_q == 4'd7);
        last_row = ({1'b0, row_q} == (rows_q - 5'd1));
    end

    always_comb begin
        state_d    = state_q;
        coll_d     = coll_q;
        ram_addr_d = ram_addr_q;
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        hires_d    = hires_q;
        wide_d     = wide_q;
        x_d        = x_q;
        y_d        = y_q;
        rows_d     = rows_q;
        mask_d     = mask_q;
        sprite_d   = sprite_q;
        byte_d     = byte_q;
        px_d       = px_q;
        row_d      = row_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hires_d    = hires;
                    x_d        = hires ? {1'b0, x[6:0]} : {2'b00, x[5:0]};
                    y_d        = hires ? {2'b00, y[5:0]} : {3'b000, y[4:0]};
                    wide_d     = hires && (n == 4'd0);
                    rows_d     = (hires && (n == 4'd0)) ? 5'd16 : {1'b0, n};
                    mask_d     = plane_mask;
                    coll_d     = 1'b0;
                    ram_addr_d = sprite_addr;
                    row_d      = 4'd0;
                    byte_d     = 1'b0;
                    px_d       = 4'd0;
                    // Lores n=0 draws nothing but still completes with a done pulse.
                    state_d    = (!hires && (n == 4'd0)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                sprite_d = byte_q ? {sprite_q[15:8], ram_dout} : {ram_dout, 8'h00};
                if (wide_q && !byte_q) begin
                    byte_d     = 1'b1;
                    ram_addr_d = ram_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d    = ST_FETCH;
                end else begin
                    px_d    = 4'd0;
                    hpos_d  = wrap_col(x_q, hires_q);
                    vpos_d  = wrap_row(cur_row, hires_q);
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (write_en && ((vram_pixelo & mask_q) != 2'b00)) begin
                    coll_d = 1'b1;
                end
                if (last_px) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d      = row_q + 4'd1;
                        byte_d     = 1'b0;
                        ram_addr_d = ram_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d    = ST_FETCH;
                    end
                end else begin
                    px_d    = px_q + 4'd1;
                    hpos_d  = wrap_col(nxt_col, hires_q);
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            coll_q     <= 1'b0;
            ram_addr_q <= '0;
            hpos_q     <= 7'd0;
            vpos_q     <= 6'd0;
        end else begin
            state_q    <= state_d;
            coll_q     <= coll_d;
            ram_addr_q <= ram_addr_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
        end
    end

    // Draw context and sprite data are only meaningful once a draw has been accepted.
    always_ff @(posedge clk) begin
        hires_q  <= hires_d;
        wide_q   <= wide_d;
        x_q      <= x_d;
        y_q      <= y_d;
        rows_q   <= rows_d;
        mask_q   <= mask_d;
        sprite_q <= sprite_d;
        byte_q   <= byte_d;
        px_q     <= px_d;
        row_q    <= row_d;
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign collision   = coll_q;
    assign ram_addr    = ram_addr_q;
    assign vram_hpos   = hpos_q;
    assign vram_vpos   = vpos_q;
    assign vram_we     = write_en;
    assign vram_pixeli = write_en ? (vram_pixelo ^ mask_q) : 2'b00;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: RAM/VRAM models, vector table of draws, scoreboard of expected VRAM writes.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        hires;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  n;
    logic [15:0] sprite_addr;
    logic [1:0]  plane_mask;
    logic        busy;
    logic        done;
    logic        collision;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [6:0]  vram_hpos;
    logic [5:0]  vram_vpos;
    logic [1:0]  vram_pixelo;
    logic [1:0]  vram_pixeli;
    logic        vram_we;

    always #5 clk = ~clk;

    sprite_blitter #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .hires(hires), .x(x), .y(y), .n(n),
        .sprite_addr(sprite_addr), .plane_mask(plane_mask), .busy(busy), .done(done),
        .collision(collision), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixelo(vram_pixelo),
        .vram_pixeli(vram_pixeli), .vram_we(vram_we)
    );

    typedef struct {
        logic        hires;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  n;
        logic [15:0] addr;
        logic [1:0]  mask;
        int          exp_writes;
        logic        exp_coll;
        int          exp_done;
    } vec_t;

    typedef struct packed {
        logic [6:0] h;
        logic [5:0] v;
        logic [1:0] d;
    } wr_t;

`ifdef SPRITE_WRAP_EN
    localparam int W_CORNER = 16;
    localparam int W_HIRES  = 256;
    localparam int W_EDGE   = 4;
`else
    localparam int W_CORNER = 2;
    localparam int W_HIRES  = 128;
    localparam int W_EDGE   = 2;
`endif

    logic [7:0] ram    [0:65535];
    logic [1:0] vram   [0:63][0:127];
    logic [1:0] shadow [0:63][0:127];

    wr_t        exp_q[$];
    logic [15:0] addr_log[$];
    int         checks = 0;
    int         errors = 0;
    int         wr_count = 0;

    always @(posedge clk) begin
        ram_dout    <= ram[ram_addr];
        vram_pixelo <= vram[vram_vpos][vram_hpos];
        if (vram_we) vram[vram_vpos][vram_hpos] <= vram_pixeli;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            wr_t got;
            wr_count++;
            got = '{vram_hpos, vram_vpos, vram_pixeli};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h want none", got);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("vram_write", 32'(got), 32'(e));
            end
        end
        if (busy === 1'b1 && (addr_log.size() == 0 || addr_log[$] != ram_addr))
            addr_log.push_back(ram_addr);
    end

    // Reference draw on the bench's own VRAM shadow; queues every write it expects.
    task automatic model_draw(input vec_t v);
        int xw, yw, rows, wb, wid, hgt, col, row;
        logic [7:0] b8;
        logic [1:0] old;
        wid  = v.hires ? 128 : 64;
        hgt  = v.hires ? 64 : 32;
        xw   = int'(v.x) % wid;
        yw   = int'(v.y) % hgt;
        rows = (v.hires && v.n == 0) ? 16 : int'(v.n);
        wb   = (v.hires && v.n == 0) ? 2 : 1;
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < wb; b++) begin
                b8 = ram[16'(int'(v.addr) + r * wb + b)];
                for (int i = 0; i < 8; i++) begin
                    col = xw + b * 8 + i;
                    row = yw + r;
`ifdef SPRITE_WRAP_EN
                    col = col % wid;
                    row = row % hgt;
`endif
                    if (b8[7-i] && v.mask != 2'b00 && col < wid && row < hgt) begin
                        old = shadow[row][col];
                        shadow[row][col] = old ^ v.mask;
                        exp_q.push_back('{7'(col), 6'(row), old ^ v.mask});
                    end
                end
            end
        end
    endtask

    task automatic drive(input vec_t v);
        hires = v.hires; x = v.x; y = v.y; n = v.n;
        sprite_addr = v.addr; plane_mask = v.mask; start = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc, done_cyc;
        logic coll_at_done;
        model_draw(v);
        wr_count = 0;
        @(negedge clk);
        addr_log.delete();
        drive(v);
        cyc = 0;
        done_cyc = -1;
        coll_at_done = 1'bx;
        while (cyc < 1200 && done_cyc < 0) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
            if (done === 1'b1) begin
                done_cyc = cyc;
                coll_at_done = collision;
            end
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        check({tag, "_collision"}, 32'(coll_at_done), 32'(v.exp_coll));
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_coll_held"}, 32'(collision), 32'(v.exp_coll));
        check({tag, "_writes"}, 32'(wr_count), 32'(v.exp_writes));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int cyc, ndone, first_done;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 128; c++) begin
                vram[r][c] = 2'b00;
                shadow[r][c] = 2'b00;
            end
        ram[16'h0200] = 8'hF0;
        ram[16'h0210] = 8'hFF;
        ram[16'h0211] = 8'hFF;
        for (int i = 0; i < 32; i++) ram[16'h0300 + i] = 8'hFF;
        ram[16'h0400] = 8'hA5;
        ram[16'hFFFF] = 8'h80;
        ram[16'h0000] = 8'h01;

        //           hires  x       y       n     addr       mask   writes    coll  done
        vecs[0] = '{1'b0, 8'd0,   8'd0,   4'd1, 16'h0200, 2'b01, 4,        1'b0, 19};
        vecs[1] = '{1'b0, 8'd0,   8'd0,   4'd1, 16'h0200, 2'b01, 4,        1'b1, 19};
        vecs[2] = '{1'b0, 8'd62,  8'd31,  4'd2, 16'h0210, 2'b01, W_CORNER, 1'b0, 37};
        vecs[3] = '{1'b0, 8'd62,  8'd31,  4'd2, 16'h0210, 2'b01, W_CORNER, 1'b1, 37};
        vecs[4] = '{1'b1, 8'd120, 8'd0,   4'd0, 16'h0300, 2'b10, W_HIRES,  1'b0, 577};
        vecs[5] = '{1'b1, 8'd124, 8'd2,   4'd1, 16'h0400, 2'b11, W_EDGE,   1'b1, 19};
        vecs[6] = '{1'b0, 8'd5,   8'd5,   4'd1, 16'h0200, 2'b00, 0,        1'b0, 19};
        vecs[7] = '{1'b0, 8'd9,   8'd9,   4'd0, 16'h0200, 2'b01, 0,        1'b0, 1};
        vecs[8] = '{1'b1, 8'd200, 8'd70,  4'd1, 16'h0200, 2'b01, 4,        1'b0, 19};
        vecs[9] = '{1'b0, 8'd10,  8'd10,  4'd2, 16'hFFFF, 2'b01, 2,        1'b0, 37};

        reset = 1'b1; start = 1'b0; hires = 1'b0; x = 8'd0; y = 8'd0; n = 4'd0;
        sprite_addr = 16'd0; plane_mask = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'd0, busy, done, collision, vram_we}, 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_vpos_hpos_pix", {17'd0, vram_vpos, vram_hpos, vram_pixeli}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 4) begin
                check("vec4_addr_count", 32'(addr_log.size()), 32'd32);
                for (int k = 0; k < addr_log.size() && k < 32; k++)
                    check($sformatf("vec4_addr%0d", k), 32'(addr_log[k]), 32'(16'h0300 + k));
            end
            if (i == 3) begin
                int nz = 0;
                for (int r = 0; r < 32; r++)
                    for (int c = 0; c < 64; c++)
                        if (vram[r][c] != 2'b00) nz++;
                check("lores_vram_clear", 32'(nz), 32'd0);
            end
        end

        // Start pulsed again mid-draw must be ignored.
        v = '{1'b0, 8'd0, 8'd8, 4'd1, 16'h0200, 2'b01, 4, 1'b0, 19};
        model_draw(v);
        wr_count = 0;
        @(negedge clk);
        drive(v);
        cyc = 0; ndone = 0; first_done = -1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                x = 8'd30; y = 8'd3; n = 4'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
            end
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_done_cycle", 32'(first_done), 32'd19);
        check("ign_writes", 32'(wr_count), 32'd4);
        check("ign_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a draw: abort with no done pulse.
        v = '{1'b0, 8'd0, 8'd20, 4'd2, 16'h0200, 2'b01, 4, 1'b0, 37};
        model_draw(v);
        wr_count = 0;
        @(negedge clk);
        drive(v);
        cyc = 0; ndone = 0;
        while (cyc < 10) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done === 1'b1) ndone++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_we", 32'(vram_we), 32'd0);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);
        check("rst_mid_writes", 32'(wr_count), 32'd4);
        check("rst_mid_sb_empty", 32'(exp_q.size()), 32'd0);
        check("rst_mid_pixel", 32'(vram[20][3]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
